// File: rtl/fetch_stage_router.sv
// Registered fetch-stage steering router: each instruction word goes to one of CHANNELS
// one-entry holding registers with valid/ready handshake; bad selects are dropped and counted.
module fetch_stage_router #(
    parameter int WIDTH    = 22,
    parameter int CHANNELS = 2,
    parameter int SEL_W    = 1,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic                      sel_err,
    output logic [CNT_W-1:0]          drop_cnt
);

    logic [CHANNELS-1:0] full_q, full_d;
    logic [WIDTH-1:0]    data_q [CHANNELS];
    logic [WIDTH-1:0]    data_d [CHANNELS];
    logic                sel_err_q, sel_err_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic [CHANNELS-1:0] sel_hit;
    logic [CHANNELS-1:0] load;
    logic                sel_ok;
    logic                accept;
    logic                drop;

    // One-hot decode keeps out-of-range selects from ever indexing a channel.
    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sel_hit[k] = (32'(in_sel) == $unsigned(k));
        end
        sel_ok = |sel_hit;

        if (flush) begin
            in_ready = 1'b0;
        end else if (!sel_ok) begin
            in_ready = 1'b1;
        end else begin
            in_ready = |(sel_hit & (~full_q | out_ready));
        end

        accept = in_valid & in_ready;
        drop   = accept & ~sel_ok;
        load   = {CHANNELS{accept}} & sel_hit;
    end

    always_comb begin
        full_d     = full_q;
        sel_err_d  = sel_err_q | drop;
        drop_cnt_d = drop_cnt_q;
        for (int k = 0; k < CHANNELS; k++) begin
            data_d[k] = data_q[k];
            if (flush) begin
                full_d[k] = 1'b0;
            end else if (load[k]) begin
                full_d[k] = 1'b1;
                data_d[k] = in_data;
            end else if (full_q[k] && out_ready[k]) begin
                full_d[k] = 1'b0;
            end
        end
        if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= '0;
            sel_err_q  <= 1'b0;
            drop_cnt_q <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            full_q     <= full_d;
            sel_err_q  <= sel_err_d;
            drop_cnt_q <= drop_cnt_d;
            for (int k = 0; k < CHANNELS; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Stale words stay in data_q after a drain, so empty channels are masked to zero.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (full_q[k]) begin
                out_data[k*WIDTH +: WIDTH] = data_q[k];
            end
        end
    end

    assign out_valid = full_q;
    assign sel_err   = sel_err_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fetch_stage_router.sv
// Self-checking bench for fetch_stage_router: a 2-channel and a 3-channel instance
// checked against a per-channel occupancy model under directed and random stimulus.
module tb_fetch_stage_router;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [21:0] in_data;
    logic        sel2;
    logic [1:0]  sel3;
    logic [1:0]  ordy2;
    logic [2:0]  ordy3;

    logic        rdy2, rdy3;
    logic [43:0] od2;
    logic [65:0] od3;
    logic [1:0]  ov2;
    logic [2:0]  ov3;
    logic        err2, err3;
    logic [7:0]  cnt2, cnt3;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model: per-instance, per-channel "holds a word" flag plus the word
    bit          mhas  [2][3];
    logic [21:0] mword [2][3];
    int          mdrop [2];
    bit          merr  [2];

    logic lastRdy2, lastRdy3;

    fetch_stage_router u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_sel(sel2), .in_valid(in_valid), .in_ready(rdy2),
        .out_data(od2), .out_valid(ov2), .out_ready(ordy2),
        .sel_err(err2), .drop_cnt(cnt2)
    );

    fetch_stage_router #(.WIDTH(22), .CHANNELS(3), .SEL_W(2), .CNT_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_sel(sel3), .in_valid(in_valid), .in_ready(rdy3),
        .out_data(od3), .out_valid(ov3), .out_ready(ordy3),
        .sel_err(err3), .drop_cnt(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int chCount(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic bit expReady(input int d);
        int s;
        logic [2:0] r;
        s = (d == 0) ? int'(sel2) : int'(sel3);
        r = (d == 0) ? {1'b0, ordy2} : ordy3;
        if (flush) return 1'b0;
        if (s >= chCount(d)) return 1'b1;
        return !mhas[d][s] || r[s];
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mdrop[d] = 0;
            merr[d]  = 1'b0;
            for (int k = 0; k < 3; k++) begin
                mhas[d][k]  = 1'b0;
                mword[d][k] = '0;
            end
        end
    endtask

    task automatic modelClock(input int d);
        int s;
        logic [2:0] r;
        bit acc;
        s   = (d == 0) ? int'(sel2) : int'(sel3);
        r   = (d == 0) ? {1'b0, ordy2} : ordy3;
        acc = in_valid && expReady(d);
        if (flush) begin
            for (int k = 0; k < 3; k++) mhas[d][k] = 1'b0;
            return;
        end
        for (int k = 0; k < chCount(d); k++) begin
            if (mhas[d][k] && r[k]) mhas[d][k] = 1'b0;
        end
        if (acc) begin
            if (s < chCount(d)) begin
                mhas[d][s]  = 1'b1;
                mword[d][s] = in_data;
            end else begin
                merr[d] = 1'b1;
                if (mdrop[d] < 255) mdrop[d]++;
            end
        end
    endtask

    task automatic checkState(input string tag);
        logic [65:0] expData;
        logic [2:0]  expValid;
        for (int d = 0; d < 2; d++) begin
            expData  = '0;
            expValid = '0;
            for (int k = 0; k < chCount(d); k++) begin
                if (mhas[d][k]) begin
                    expValid[k]         = 1'b1;
                    expData[k*22 +: 22] = mword[d][k];
                end
            end
            if (d == 0) begin
                checkOutput({tag, "_valid2"}, 66'(ov2), 66'(expValid));
                checkOutput({tag, "_data2"}, 66'(od2), expData);
                checkOutput({tag, "_err2"}, 66'(err2), 66'(merr[0]));
                checkOutput({tag, "_cnt2"}, 66'(cnt2), 66'(mdrop[0]));
            end else begin
                checkOutput({tag, "_valid3"}, 66'(ov3), 66'(expValid));
                checkOutput({tag, "_data3"}, od3, expData);
                checkOutput({tag, "_err3"}, 66'(err3), 66'(merr[1]));
                checkOutput({tag, "_cnt3"}, 66'(cnt3), 66'(mdrop[1]));
            end
        end
    endtask

    // One full cycle: drive inputs after a falling edge, check in_ready, clock, check registers.
    task automatic applyStimulus(input string tag, input bit fl, input bit v, input logic [21:0] dat,
                                 input logic s2, input logic [1:0] s3,
                                 input logic [1:0] r2, input logic [2:0] r3);
        flush    = fl;
        in_valid = v;
        in_data  = dat;
        sel2     = s2;
        sel3     = s3;
        ordy2    = r2;
        ordy3    = r3;
        #1;
        lastRdy2 = rdy2;
        lastRdy3 = rdy3;
        checkOutput({tag, "_rdy2"}, 66'(rdy2), 66'(expReady(0)));
        checkOutput({tag, "_rdy3"}, 66'(rdy3), 66'(expReady(1)));
        modelClock(0);
        modelClock(1);
        @(posedge clk);
        @(negedge clk);
        checkState(tag);
    endtask

    initial begin
        bit          hv;
        logic [21:0] hd;
        logic        hs2;
        logic [1:0]  hs3;

        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        sel2     = 1'b0;
        sel3     = 2'd0;
        ordy2    = 2'b00;
        ordy3    = 3'b000;
        modelReset();
        #1;
        checkState("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single transfer to channel 1");
        applyStimulus("tp1", 0, 1, 22'h2A5A5, 1'b1, 2'd0, 2'b11, 3'b111);
        checkOutput("tp1_ov", 66'(ov2), 66'(2'b10));
        checkOutput("tp1_ch1", 66'(od2[43:22]), 66'(22'h2A5A5));
        checkOutput("tp1_ch0", 66'(od2[21:0]), 66'(0));
        applyStimulus("tp1b", 0, 0, 22'h0, 1'b0, 2'd0, 2'b11, 3'b111);
        checkOutput("tp1_ov_drained", 66'(ov2), 66'(0));

        $display("[TB] back-pressure on channel 0");
        applyStimulus("bp1", 0, 1, 22'h1, 1'b0, 2'd0, 2'b00, 3'b111);
        applyStimulus("bp2", 0, 1, 22'h2, 1'b0, 2'd0, 2'b00, 3'b111);
        checkOutput("bp_stall_rdy", 66'(lastRdy2), 66'(0));
        checkOutput("bp_hold_data", 66'(od2[21:0]), 66'(22'h1));
        applyStimulus("bp3", 0, 1, 22'h2, 1'b0, 2'd0, 2'b01, 3'b111);
        checkOutput("bp_release_rdy", 66'(lastRdy2), 66'(1));
        checkOutput("bp_no_bubble", 66'(ov2[0]), 66'(1));
        checkOutput("bp_new_data", 66'(od2[21:0]), 66'(22'h2));

        $display("[TB] channel independence");
        applyStimulus("ind", 0, 1, 22'h3FFFF, 1'b1, 2'd0, 2'b00, 3'b111);
        checkOutput("ind_rdy", 66'(lastRdy2), 66'(1));
        checkOutput("ind_ov", 66'(ov2), 66'(2'b11));
        checkOutput("ind_ch0", 66'(od2[21:0]), 66'(22'h2));
        checkOutput("ind_ch1", 66'(od2[43:22]), 66'(22'h3FFFF));

        $display("[TB] flush with both channels full");
        applyStimulus("fl1", 1, 1, 22'h155, 1'b0, 2'd1, 2'b00, 3'b000);
        checkOutput("fl_rdy", 66'(lastRdy2), 66'(0));
        checkOutput("fl_ov", 66'(ov2), 66'(0));
        applyStimulus("fl2", 0, 1, 22'h155, 1'b0, 2'd1, 2'b00, 3'b000);
        checkOutput("fl_after_rdy", 66'(lastRdy2), 66'(1));
        checkOutput("fl_after_ov", 66'(ov2), 66'(2'b01));
        checkOutput("fl_after_data", 66'(od2[21:0]), 66'(22'h155));

        $display("[TB] out-of-range select saturation");
        for (int i = 0; i < 300; i++) begin
            applyStimulus("sat", 0, 1, 22'($urandom), 1'b0, 2'd3, 2'b11, 3'b111);
        end
        checkOutput("sat_rdy", 66'(lastRdy3), 66'(1));
        checkOutput("sat_ov", 66'(ov3), 66'(0));
        checkOutput("sat_err", 66'(err3), 66'(1));
        checkOutput("sat_cnt", 66'(cnt3), 66'(255));

        $display("[TB] random traffic");
        hv = 0; hd = '0; hs2 = 0; hs3 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(hv && !(lastRdy2 && lastRdy3))) begin
                hv  = ($urandom_range(0, 3) != 0);
                hd  = 22'($urandom);
                hs2 = 1'($urandom);
                hs3 = 2'($urandom);
            end
            applyStimulus("rnd", ($urandom_range(0, 15) == 0), hv, hd, hs2, hs3,
                          2'($urandom), 3'($urandom));
        end

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus("pre1", 0, 1, 22'h0ABC, 1'b0, 2'd3, 2'b00, 3'b000);
        applyStimulus("pre2", 0, 1, 22'h0DEF, 1'b1, 2'd0, 2'b00, 3'b000);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("ar_ov2", 66'(ov2), 66'(0));
        checkOutput("ar_od2", 66'(od2), 66'(0));
        checkOutput("ar_ov3", 66'(ov3), 66'(0));
        checkOutput("ar_err3", 66'(err3), 66'(0));
        checkOutput("ar_cnt3", 66'(cnt3), 66'(0));
        checkState("ar");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("post", 0, 1, 22'h12345, 1'b1, 2'd2, 2'b00, 3'b000);
        checkOutput("post_ov2", 66'(ov2), 66'(2'b10));
        checkOutput("post_ch1", 66'(od2[43:22]), 66'(22'h12345));
        checkOutput("post_ov3", 66'(ov3), 66'(3'b100));
        applyStimulus("post2", 0, 0, 22'h0, 1'b0, 2'd0, 2'b11, 3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
